vend_transaction_ctrl: RTL

- Transaction controller directly downstream of the money-input stage (accumulated credit) and the product-selection stage (registered price).
- On a buy request it checks credit against price and per-slot stock, then drives the selected slot's dispense motor.
- It returns change one coin at a time over a valid/ready handshake to the change hopper, then pulses a clear back to the money stage.
- It also handles cancel (full refund) and holds stock counters for the 8 slots.

---
 rtl/vend_transaction_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/vend_transaction_ctrl.sv
// Vending transaction controller: credit/price/stock check, timed motor pulse,
// greedy change payout over a valid/ready handshake, and a credit-clear pulse.
module vend_transaction_ctrl #(
  parameter logic [7:0]  STOCK_INIT      = 8'd5,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] credit,
  input  logic [15:0] price,
  input  logic [2:0]  address,
  input  logic        buy,
  input  logic        cancel,
  input  logic        restock,
  input  logic        coin_ready,
  output logic        coin_valid,
  output logic [3:0]  coin_type,
  output logic [7:0]  motor,
  output logic        busy,
  output logic [1:0]  status,
  output logic        credit_clear
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_VEND,
    S_CHANGE,
    S_CLEAR
  } state_t;

  localparam logic [1:0]  ST_OK        = 2'b00;
  localparam logic [1:0]  ST_NO_CREDIT = 2'b01;
  localparam logic [1:0]  ST_SOLD_OUT  = 2'b10;
  localparam logic [1:0]  ST_BAD_PRICE = 2'b11;
  localparam logic [15:0] COIN_MIN     = 16'd500;
  localparam logic [7:0]  LAST_CNT     = 8'(DISPENSE_CYCLES - 1);

  // Largest coin not exceeding the amount; zero when nothing can be paid out.
  function automatic logic [3:0] coin_for(input logic [15:0] amount);
    if (amount >= 16'd5000)      return 4'b1000;
    else if (amount >= 16'd2000) return 4'b0100;
    else if (amount >= 16'd1000) return 4'b0010;
    else if (amount >= 16'd500)  return 4'b0001;
    else                         return 4'b0000;
  endfunction

  function automatic logic [15:0] coin_value(input logic [3:0] kind);
    case (kind)
      4'b1000: return 16'd5000;
      4'b0100: return 16'd2000;
      4'b0010: return 16'd1000;
      4'b0001: return 16'd500;
      default: return 16'd0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic [15:0] credit_q, credit_d;
  logic [15:0] price_q, price_d;
  logic [2:0]  addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] rem_next;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  status_q, status_d;
  logic        coin_valid_q, coin_valid_d;
  logic [3:0]  coin_type_q, coin_type_d;
  logic [7:0]  stock_q [8];
  logic [7:0]  stock_d [8];

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; an unassigned path in always_comb would infer a latch.
  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    price_d      = price_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    rem_next     = rem_q;
    cnt_d        = cnt_q;
    status_d     = status_q;
    coin_valid_d = coin_valid_q;
    coin_type_d  = coin_type_q;
    stock_d      = stock_q;

    case (state_q)
      S_IDLE: begin
        if (restock) begin
          for (int i = 0; i < 8; i++) stock_d[i] = STOCK_INIT;
        end
        if (cancel) begin
          rem_d        = credit;
          status_d     = ST_OK;
          coin_valid_d = (credit >= COIN_MIN);
          coin_type_d  = coin_for(credit);
          state_d      = S_CHANGE;
        end else if (buy) begin
          credit_d = credit;
          price_d  = price;
          addr_d   = address;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        state_d = S_IDLE;
        if (price_q == 16'd0) begin
          status_d = ST_BAD_PRICE;
        end else if (stock_q[addr_q] == 8'd0) begin
          status_d = ST_SOLD_OUT;
        end else if (credit_q < price_q) begin
          status_d = ST_NO_CREDIT;
        end else begin
          status_d         = ST_OK;
          rem_d            = credit_q - price_q;
          stock_d[addr_q]  = stock_q[addr_q] - 8'd1;
          cnt_d            = 8'd0;
          state_d          = S_VEND;
        end
      end

      S_VEND: begin
        if (cnt_q == LAST_CNT) begin
          if (rem_q >= COIN_MIN) begin
            coin_valid_d = 1'b1;
            coin_type_d  = coin_for(rem_q);
            state_d      = S_CHANGE;
          end else begin
            state_d = S_CLEAR;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      S_CHANGE: begin
        // A presented coin is held until accepted; the following coin is
        // chosen from the post-payment remainder so handshakes can run back to back.
        if (!coin_valid_q || coin_ready) begin
          rem_next = coin_valid_q ? (rem_q - coin_value(coin_type_q)) : rem_q;
          rem_d    = rem_next;
          if (rem_next >= COIN_MIN) begin
            coin_valid_d = 1'b1;
            coin_type_d  = coin_for(rem_next);
          end else begin
            coin_valid_d = 1'b0;
            coin_type_d  = 4'b0000;
            state_d      = S_CLEAR;
          end
        end
      end

      S_CLEAR: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      credit_q     <= '0;
      price_q      <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      cnt_q        <= '0;
      status_q     <= ST_OK;
      coin_valid_q <= 1'b0;
      coin_type_q  <= '0;
      // NOTE: the stock array is a small register file with a defined reset
      // value, so it is reset here rather than mapped to an unreset RAM.
      for (int i = 0; i < 8; i++) stock_q[i] <= STOCK_INIT;
    end else begin
      state_q      <= state_d;
      credit_q     <= credit_d;
      price_q      <= price_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      cnt_q        <= cnt_d;
      status_q     <= status_d;
      coin_valid_q <= coin_valid_d;
      coin_type_q  <= coin_type_d;
      stock_q      <= stock_d;
    end
  end

  assign coin_valid   = coin_valid_q;
  assign coin_type    = coin_type_q;
  assign motor        = (state_q == S_VEND) ? (8'd1 << addr_q) : 8'd0;
  assign busy         = (state_q != S_IDLE);
  assign status       = status_q;
  assign credit_clear = (state_q == S_CLEAR);

endmodule
